// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the PC, runs the imem req/ack handshake,
// loads IF/ID. One-entry skid for ID stalls; deferred redirect.
module fetch_stage #(
  parameter int              SIZE     = 32,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [SIZE-1:0] br_pc_plus4,
  input  logic [SIZE-1:0] br_offset_sh,
  input  logic            jump,
  input  logic [25:0]     jump_target,
  output logic            imem_req,
  output logic [SIZE-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [SIZE-1:0] imem_rdata,
  output logic [SIZE-1:0] if_id_instr,
  output logic [SIZE-1:0] if_id_pc_plus4,
  output logic            if_id_valid
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_WAIT,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic            r_req;
  logic            r_valid;
  logic [SIZE-1:0] r_pc;
  logic [SIZE-1:0] r_redir_pc;
  logic [SIZE-1:0] r_skid_instr;
  logic [SIZE-1:0] r_skid_pc4;
  logic [SIZE-1:0] r_instr;
  logic [SIZE-1:0] r_pc4;

  logic            w_redir;
  logic [SIZE-1:0] w_pc4;
  logic [SIZE-1:0] w_br_tgt;
  logic [SIZE-1:0] w_j_tgt;
  logic [SIZE-1:0] w_target;

  // Redirects only count when ID holds a real, non-stalled instruction.
  assign w_redir  = r_valid & ~stall & (jump | br_taken);
  assign w_pc4    = r_pc + SIZE'(4);
  assign w_br_tgt = br_pc_plus4 + br_offset_sh;
  assign w_j_tgt  = {r_pc4[SIZE-1 -: 4], jump_target, 2'b00};
  assign w_target = jump ? w_j_tgt : w_br_tgt;

  assign imem_req       = r_req;
  assign imem_addr      = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc_plus4 = r_pc4;
  assign if_id_valid    = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_req        <= 1'b0;
      r_valid      <= 1'b0;
      r_pc         <= RESET_PC;
      r_redir_pc   <= '0;
      r_skid_instr <= '0;
      r_skid_pc4   <= '0;
      r_instr      <= '0;
      r_pc4        <= '0;
    end else begin
      unique case (r_state)
        S_BOOT: begin
          r_state <= S_WAIT;
          r_req   <= 1'b1;
        end
        S_WAIT: begin
          if (w_redir) begin
            r_valid <= 1'b0;
            if (imem_ack) begin
              r_pc <= w_target;
            end else begin
              // addr must stay put until the old request is acked
              r_redir_pc <= w_target;
              r_state    <= S_DRAIN;
            end
          end else if (imem_ack && !stall) begin
            r_instr <= imem_rdata;
            r_pc4   <= w_pc4;
            r_valid <= 1'b1;
            r_pc    <= w_pc4;
          end else if (imem_ack) begin
            r_skid_instr <= imem_rdata;
            r_skid_pc4   <= w_pc4;
            r_pc         <= w_pc4;
            r_req        <= 1'b0;
            r_state      <= S_HOLD;
          end else if (!stall) begin
            // ID consumed its instruction, nothing new arrived
            r_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            r_pc    <= r_redir_pc;
            r_state <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_req   <= 1'b1;
            r_state <= S_WAIT;
            if (w_redir) begin
              r_pc    <= w_target;
              r_valid <= 1'b0;
            end else begin
              r_instr <= r_skid_instr;
              r_pc4   <= r_skid_pc4;
              r_valid <= 1'b1;
            end
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run
// checked against a program-order model of delivered instructions.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc_plus4 = '0;
  logic [31:0] br_offset_sh = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;

  logic ack_en = 1'b0;
  logic ack_force = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h2008_0001 + (a >> 2) * 32'h0001_0001;
  endfunction

  assign imem_ack   = ack_force | (ack_en & imem_req);
  assign imem_rdata = mem(imem_addr);

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .br_taken      (br_taken),
    .br_pc_plus4   (br_pc_plus4),
    .br_offset_sh  (br_offset_sh),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({imem_req, if_id_valid} !== 2'b00 || if_id_instr !== 32'h0 ||
        if_id_pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset req/v=%b%b instr=%h pc4=%h addr=%h exp all 0",
               imem_req, if_id_valid, if_id_instr, if_id_pc_plus4, imem_addr);
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL boot req=%b addr=%h v=%b exp 1 0 0",
               imem_req, imem_addr, if_id_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (if_id_valid !== 1'b1 ||
          if_id_pc_plus4 !== 32'(4 * (i + 1)) ||
          if_id_instr !== mem(32'(4 * i)) ||
          imem_addr !== 32'(4 * (i + 1))) begin
        n_err++;
        $display("FAIL seq%0d v=%b pc4=%h instr=%h addr=%h exp pc4=%h",
                 i, if_id_valid, if_id_pc_plus4, if_id_instr, imem_addr,
                 32'(4 * (i + 1)));
      end
    end
  endtask

  // Take a branch from the ack-every-cycle steady state.
  task automatic do_branch(input string nm, input logic [31:0] p4,
                           input logic [31:0] off, input logic [31:0] tgt);
    br_taken     = 1'b1;
    br_pc_plus4  = p4;
    br_offset_sh = off;
    step();
    br_taken = 1'b0;
    n_vec++;
    if (imem_addr !== tgt || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_redir addr=%h v=%b exp %h 0",
               nm, imem_addr, if_id_valid, tgt);
    end
    step();
    n_vec++;
    if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== tgt + 4 ||
        if_id_instr !== mem(tgt)) begin
      n_err++;
      $display("FAIL %s_land v=%b pc4=%h instr=%h exp pc4=%h",
               nm, if_id_valid, if_id_pc_plus4, if_id_instr, tgt + 4);
    end
  endtask

  task automatic test_branch();
    do_branch("br_fwd", 32'h10, 32'h20, 32'h30);
    do_branch("br_bwd", 32'h100, 32'hFFFF_FFF0, 32'hF0);
  endtask

  task automatic test_jump();
    do_branch("br_hi", 32'h4000_0000, 32'h0C, 32'h4000_000C);
    jump         = 1'b1;
    br_taken     = 1'b1;
    jump_target  = 26'h40;
    br_pc_plus4  = 32'h10;
    br_offset_sh = 32'h20;
    step();
    jump     = 1'b0;
    br_taken = 1'b0;
    n_vec++;
    if (imem_addr !== 32'h4000_0100 || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL jump addr=%h v=%b exp 40000100 0", imem_addr, if_id_valid);
    end
    step();
    n_vec++;
    if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h4000_0104) begin
      n_err++;
      $display("FAIL jump_land v=%b pc4=%h exp 1 40000104",
               if_id_valid, if_id_pc_plus4);
    end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] old_addr;
    old_addr     = imem_addr;
    ack_en       = 1'b0;
    br_taken     = 1'b1;
    br_pc_plus4  = 32'h200;
    br_offset_sh = 32'h0;
    step();
    br_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== old_addr || if_id_valid !== 1'b0) begin
        n_err++;
        $display("FAIL drain%0d req=%b addr=%h v=%b exp 1 %h 0",
                 i, imem_req, imem_addr, if_id_valid, old_addr);
      end
      if (i == 2) ack_en = 1'b1;
      step();
    end
    n_vec++;
    if (imem_addr !== 32'h200 || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_done addr=%h v=%b exp 200 0", imem_addr, if_id_valid);
    end
    step();
    n_vec++;
    if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h204 ||
        if_id_instr !== mem(32'h200)) begin
      n_err++;
      $display("FAIL drain_land v=%b pc4=%h instr=%h exp 1 204 %h",
               if_id_valid, if_id_pc_plus4, if_id_instr, mem(32'h200));
    end
  endtask

  task automatic test_stall_skid(input logic with_br);
    logic [31:0] p4;
    p4    = if_id_pc_plus4;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (imem_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc_plus4 !== p4 ||
          if_id_instr !== mem(p4 - 4)) begin
        n_err++;
        $display("FAIL hold%0d req=%b v=%b pc4=%h exp 0 1 %h",
                 i, imem_req, if_id_valid, if_id_pc_plus4, p4);
      end
    end
    stall = 1'b0;
    if (with_br) begin
      br_taken     = 1'b1;
      br_pc_plus4  = 32'h300;
      br_offset_sh = 32'h0;
      step();
      br_taken = 1'b0;
      n_vec++;
      if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
        n_err++;
        $display("FAIL skid_redir v=%b req=%b addr=%h exp 0 1 300",
                 if_id_valid, imem_req, imem_addr);
      end
      step();
      n_vec++;
      if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h304) begin
        n_err++;
        $display("FAIL skid_drop v=%b pc4=%h exp 1 304",
                 if_id_valid, if_id_pc_plus4);
      end
    end else begin
      step();
      n_vec++;
      if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== p4 + 4 ||
          if_id_instr !== mem(p4) || imem_req !== 1'b1 ||
          imem_addr !== p4 + 4) begin
        n_err++;
        $display("FAIL skid_out v=%b pc4=%h instr=%h addr=%h exp pc4=%h",
                 if_id_valid, if_id_pc_plus4, if_id_instr, imem_addr, p4 + 4);
      end
      step();
      n_vec++;
      if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== p4 + 8) begin
        n_err++;
        $display("FAIL skid_next v=%b pc4=%h exp 1 %h",
                 if_id_valid, if_id_pc_plus4, p4 + 8);
      end
    end
  endtask

  task automatic test_reset_drain();
    ack_en       = 1'b0;
    br_taken     = 1'b1;
    br_pc_plus4  = 32'h400;
    br_offset_sh = 32'h0;
    step();
    br_taken = 1'b0;
    #2;
    rst_n     = 1'b0;
    ack_force = 1'b1;
    #1;
    n_vec++;
    if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid req=%b v=%b addr=%h exp 0 0 0",
               imem_req, if_id_valid, imem_addr);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    ack_force = 1'b0;
    ack_en    = 1'b1;
    step();
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_boot req=%b addr=%h v=%b exp 1 0 0",
               imem_req, imem_addr, if_id_valid);
    end
    step();
    n_vec++;
    if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h4) begin
      n_err++;
      $display("FAIL rst_first v=%b pc4=%h exp 1 4", if_id_valid, if_id_pc_plus4);
    end
  endtask

  // Model: ID sees instructions in program order; after each consumed
  // instruction the next one delivered is at pc+4 or the redirect target.
  task automatic test_random();
    logic [31:0] exp_pc4;
    logic [31:0] p_addr;
    logic [31:0] p_instr;
    logic [31:0] p_pc4;
    logic [31:0] p_tgt;
    logic        p_req;
    logic        p_ack;
    logic        p_valid;
    logic        p_stall;
    logic        p_redir;
    int          lat;
    int          idle;
    rst_n = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    exp_pc4 = 32'h4;
    lat     = 0;
    idle    = 0;
    p_req   = 1'b0;
    p_ack   = 1'b0;
    p_valid = 1'b0;
    p_stall = 1'b0;
    p_redir = 1'b0;
    p_addr  = '0;
    p_instr = '0;
    p_pc4   = '0;
    p_tgt   = '0;
    for (int c = 0; c < 3000; c++) begin
      step();
      n_vec++;
      if (imem_addr[1:0] !== 2'b00) begin
        n_err++;
        $display("FAIL rnd_align c=%0d addr=%h", c, imem_addr);
      end
      if (p_req && !p_ack) begin
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
          n_err++;
          $display("FAIL rnd_hold_req c=%0d req=%b addr=%h exp 1 %h",
                   c, imem_req, imem_addr, p_addr);
        end
      end
      if (p_valid && p_stall) begin
        n_vec++;
        if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== p_pc4 ||
            if_id_instr !== p_instr) begin
          n_err++;
          $display("FAIL rnd_freeze c=%0d v=%b pc4=%h exp 1 %h",
                   c, if_id_valid, if_id_pc_plus4, p_pc4);
        end
      end else if (p_valid && p_redir) begin
        exp_pc4 = p_tgt + 4;
        n_vec++;
        if (if_id_valid !== 1'b0) begin
          n_err++;
          $display("FAIL rnd_bubble c=%0d v=%b exp 0", c, if_id_valid);
        end
      end else if (p_valid) begin
        exp_pc4 = p_pc4 + 4;
      end
      if (if_id_valid && !(p_valid && p_stall)) begin
        idle = 0;
        n_vec++;
        if (if_id_pc_plus4 !== exp_pc4 || if_id_instr !== mem(exp_pc4 - 4)) begin
          n_err++;
          $display("FAIL rnd_deliver c=%0d pc4=%h instr=%h exp %h %h",
                   c, if_id_pc_plus4, if_id_instr, exp_pc4, mem(exp_pc4 - 4));
        end
      end else begin
        idle++;
      end
      if (idle > 40) begin
        n_err++;
        $display("FAIL rnd_progress c=%0d no delivery for 40 cycles", c);
        break;
      end
      // next-cycle stimulus
      if (imem_req) begin
        if (lat == 0) begin
          ack_en = 1'b1;
          lat    = $urandom_range(0, 3);
        end else begin
          ack_en = 1'b0;
          lat--;
        end
      end else begin
        ack_en = 1'b0;
      end
      stall        = ($urandom_range(0, 3) == 0);
      br_taken     = if_id_valid && ($urandom_range(0, 5) == 0);
      jump         = if_id_valid && ($urandom_range(0, 7) == 0);
      br_pc_plus4  = if_id_pc_plus4;
      br_offset_sh = 32'($signed($urandom_range(0, 63)) - 32) << 2;
      jump_target  = 26'($urandom_range(0, 255));
      p_tgt   = jump ? {if_id_pc_plus4[31:28], jump_target, 2'b00}
                     : br_pc_plus4 + br_offset_sh;
      p_redir = if_id_valid && !stall && (jump || br_taken);
      p_req   = imem_req;
      p_ack   = ack_en && imem_req;
      p_addr  = imem_addr;
      p_valid = if_id_valid;
      p_stall = stall;
      p_instr = if_id_instr;
      p_pc4   = if_id_pc_plus4;
    end
    stall    = 1'b0;
    br_taken = 1'b0;
    jump     = 1'b0;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_redirect_wait();
    test_stall_skid(1'b0);
    test_stall_skid(1'b1);
    test_reset_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
